// File: rtl/uart_frame_receiver.sv
// 8N1 UART receiver: 2-FF input synchronizer, 16x-oversampled framing FSM with
// glitch/framing-error rejection, and a small show-ahead byte FIFO with valid/ready pop.
module uart_frame_receiver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic [1:0]        sync_r;
  logic              rx_s;
  state_t            state_r;
  state_t            state_nx_s;
  logic [DIV_W-1:0]  div_cnt_r;
  logic              tick_s;
  logic [TICK_W-1:0] tick_cnt_r;
  logic [2:0]        bit_cnt_r;
  logic [7:0]        shift_r;
  logic              restart_s;
  logic              bit_end_s;
  logic              shift_en_s;
  logic              push_s;
  logic              ferr_s;

  logic [7:0]        mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nx_s;
  logic              full_s;
  logic              pop_s;
  logic              push_ok_s;
  logic              ovr_s;
  logic              valid_r;
  logic              frame_err_r;
  logic              overrun_r;
  logic              busy_r;

  assign rx_s   = sync_r[1];
  assign tick_s = (div_cnt_r == DIV_LAST);

  // Input synchronizer; presets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx_i};
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Frame FSM next state and per-cycle sampling strobes.
  always_comb begin
    state_nx_s = state_r;
    restart_s  = 1'b0;
    bit_end_s  = 1'b0;
    shift_en_s = 1'b0;
    push_s     = 1'b0;
    ferr_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nx_s = ST_START;
          restart_s  = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s && (tick_cnt_r == HALF_LAST)) begin
          bit_end_s  = 1'b1;
          state_nx_s = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          state_nx_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s && (tick_cnt_r == BIT_LAST)) begin
          bit_end_s  = 1'b1;
          shift_en_s = 1'b1;
          state_nx_s = (bit_cnt_r == 3'd7) ? ST_STOP : ST_DATA;
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s && (tick_cnt_r == BIT_LAST)) begin
          bit_end_s = 1'b1;
          if (rx_s) begin
            push_s     = 1'b1;
            state_nx_s = ST_IDLE;
          end else begin
            ferr_s     = 1'b1;
            state_nx_s = ST_BREAK;
          end
        end else begin
          state_nx_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_BREAK;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Baud divider, oversample tick counter, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r  <= {DIV_W{1'b0}};
      tick_cnt_r <= {TICK_W{1'b0}};
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
    end else begin
      if (restart_s || tick_s) begin
        div_cnt_r <= {DIV_W{1'b0}};
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
      if (restart_s || bit_end_s) begin
        tick_cnt_r <= {TICK_W{1'b0}};
      end else if (tick_s) begin
        tick_cnt_r <= tick_cnt_r + TICK_W'(1);
      end else begin
        tick_cnt_r <= tick_cnt_r;
      end
      if (state_r == ST_START) begin
        bit_cnt_r <= 3'd0;
      end else if (shift_en_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      // LSB arrives first, so each new bit enters at the top.
      if (shift_en_s) begin
        shift_r <= {rx_s, shift_r[7:1]};
      end else begin
        shift_r <= shift_r;
      end
    end
  end

  assign pop_s     = valid_r & rx_ready_i;
  assign full_s    = (count_r == CNT_FULL);
  assign push_ok_s = push_s & (~full_s | pop_s);
  assign ovr_s     = push_s & full_s & ~pop_s;

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_nx_s = count_r;
    case ({push_ok_s, pop_s})
      2'b10:   count_nx_s = count_r + CNT_W'(1);
      2'b01:   count_nx_s = count_r - CNT_W'(1);
      default: count_nx_s = count_r;
    endcase
  end

  // FIFO storage, pointers and registered status/pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'd0;
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r     <= count_nx_s;
      valid_r     <= (count_nx_s != {CNT_W{1'b0}});
      frame_err_r <= ferr_s;
      overrun_r   <= ovr_s;
      busy_r      <= (state_nx_s != ST_IDLE);
    end
  end

  assign rx_data_o   = mem_r[rd_ptr_r];
  assign rx_valid_o  = valid_r;
  assign frame_err_o = frame_err_r;
  assign overrun_o   = overrun_r;
  assign busy_o      = busy_r;

endmodule
